// File: rtl/am_pkg.sv
// Shared definitions for the associative-memory similarity / argmax stage.
package am_pkg;

    localparam int DIMS_PER_CC     = 1024;
    localparam int SEQ_CYCLE_COUNT = 4;
    localparam int NUM_CLASSES     = 26;
    localparam int SCORE_W         = $clog2(DIMS_PER_CC * SEQ_CYCLE_COUNT + 1);
    localparam int CLASS_W         = $clog2(NUM_CLASSES);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        ARGMAX = 2'd1,
        DONE   = 2'd2
    } am_state_t;

    typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/am_popcount.sv
// Combinational popcount of a DIMS_PER_CC-bit vector, reduced pairwise as a
// balanced adder tree. The leaf count is rounded up to a power of two and the
// padding leaves are zero.
module am_popcount #(
    parameter int DIMS_PER_CC = 1024,
    parameter int SCORE_W     = 13
) (
    input  logic [DIMS_PER_CC-1:0] i_bits,
    output logic [SCORE_W-1:0]     o_count
);

    localparam int LEVELS = $clog2(DIMS_PER_CC);
    localparam int LEAVES = 1 << LEVELS;

    logic [SCORE_W-1:0] w_tree [0:LEAVES-1];

    // Load leaves with single bits, then fold pairwise level by level into w_tree[0].
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            w_tree[i] = '0;
            if (i < DIMS_PER_CC) begin
                w_tree[i] = SCORE_W'(i_bits[i]);
            end
        end
        for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
            for (int k = 0; k < w; k++) begin
                w_tree[k] = w_tree[2*k] + w_tree[2*k+1];
            end
        end
        o_count = w_tree[0];
    end

endmodule

// File: rtl/am_similarity_argmax.sv
// AM search consumer: accumulates per-class popcounts over the query segments,
// scans the class scores one per cycle for the maximum (lowest index wins ties)
// and presents the winner on a valid/ready result port.
module am_similarity_argmax #(
    parameter int DIMS_PER_CC     = am_pkg::DIMS_PER_CC,
    parameter int SEQ_CYCLE_COUNT = am_pkg::SEQ_CYCLE_COUNT,
    parameter int NUM_CLASSES     = am_pkg::NUM_CLASSES,
    parameter int SCORE_W         = $clog2(DIMS_PER_CC * SEQ_CYCLE_COUNT + 1),
    parameter int CLASS_W         = $clog2(NUM_CLASSES)
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             seg_valid,
    output logic                             seg_ready,
    input  logic [$clog2(SEQ_CYCLE_COUNT)-1:0] query_ctr,
    input  logic [DIMS_PER_CC-1:0]           and_array_out [0:NUM_CLASSES-1],
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [CLASS_W-1:0]               pred_class,
    output logic [SCORE_W-1:0]               pred_score,
    output logic                             seq_err
);

    import am_pkg::*;

    localparam int CTR_W = $clog2(SEQ_CYCLE_COUNT);

    am_state_t          r_state;
    am_state_t          w_next_state;

    logic [SCORE_W-1:0] r_acc [0:NUM_CLASSES-1];
    logic [SCORE_W-1:0] w_pop [0:NUM_CLASSES-1];
    logic [CTR_W-1:0]   r_exp_ctr;
    logic [CLASS_W-1:0] r_idx;
    logic [CLASS_W-1:0] r_best_class;
    logic [SCORE_W-1:0] r_best_score;
    logic               r_seq_err;

    logic               w_accept;
    logic               w_in_order;
    logic               w_last_seg;
    logic               w_query_done;
    logic               w_scan_end;
    logic               w_release;

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pop
        am_popcount #(
            .DIMS_PER_CC (DIMS_PER_CC),
            .SCORE_W     (SCORE_W)
        ) u_pop (
            .i_bits  (and_array_out[c]),
            .o_count (w_pop[c])
        );
    end

    assign w_accept     = seg_valid && (r_state == ACCUM);
    assign w_in_order   = (query_ctr == r_exp_ctr);
    assign w_last_seg   = (r_exp_ctr == CTR_W'(SEQ_CYCLE_COUNT - 1));
    assign w_query_done = w_accept && w_in_order && w_last_seg;
    assign w_scan_end   = (r_idx == CLASS_W'(NUM_CLASSES - 1));
    assign w_release    = (r_state == DONE) && result_ready;

    assign pred_class   = r_best_class;
    assign pred_score   = r_best_score;
    assign seq_err      = r_seq_err;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        w_next_state = r_state;
        seg_ready    = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            ACCUM: begin
                seg_ready = 1'b1;
                if (w_query_done) begin
                    w_next_state = ARGMAX;
                end
            end
            ARGMAX: begin
                if (w_scan_end) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    w_next_state = ACCUM;
                end
            end
            default: begin
                w_next_state = ACCUM;
            end
        endcase
    end

    // Per-class score accumulation; cleared once the result is taken.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept && w_in_order) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_acc[i] <= r_acc[i] + w_pop[i];
            end
        end else if (w_release) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_acc[i] <= '0;
            end
        end
    end

    // Expected segment index and sticky out-of-order flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_exp_ctr <= '0;
            r_seq_err <= 1'b0;
        end else if (w_accept) begin
            if (!w_in_order) begin
                r_seq_err <= 1'b1;
            end else if (w_last_seg) begin
                r_exp_ctr <= '0;
            end else begin
                r_exp_ctr <= r_exp_ctr + CTR_W'(1);
            end
        end
    end

    // Sequential argmax scan, one class per cycle; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_idx        <= '0;
            r_best_score <= '0;
            r_best_class <= '0;
        end else if (w_query_done) begin
            r_idx        <= '0;
            r_best_score <= '0;
            r_best_class <= '0;
        end else if (r_state == ARGMAX) begin
            if (r_acc[r_idx] > r_best_score) begin
                r_best_score <= r_acc[r_idx];
                r_best_class <= r_idx;
            end
            r_idx <= r_idx + CLASS_W'(1);
        end
    end

endmodule

// File: tb/tb_am_similarity_argmax.sv
// Self-checking bench for am_similarity_argmax with a score/argmax reference model.
module tb_am_similarity_argmax;

    localparam int D  = 1024;
    localparam int S  = 4;
    localparam int NC = 26;
    localparam int SW = 13;
    localparam int CW = 5;

    logic          clk;
    logic          nrst;
    logic          seg_valid;
    logic          seg_ready;
    logic [1:0]    query_ctr;
    logic [D-1:0]  and_array_out [0:NC-1];
    logic          result_valid;
    logic          result_ready;
    logic [CW-1:0] pred_class;
    logic [SW-1:0] pred_score;
    logic          seq_err;

    // slots 0..3 hold the in-order segments, slot 4 holds a segment meant to be dropped
    logic [D-1:0]  seg_data [0:4][0:NC-1];

    int n_vec;
    int n_err;

    am_similarity_argmax dut (
        .clk           (clk),
        .nrst          (nrst),
        .seg_valid     (seg_valid),
        .seg_ready     (seg_ready),
        .query_ctr     (query_ctr),
        .and_array_out (and_array_out),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .pred_class    (pred_class),
        .pred_score    (pred_score),
        .seq_err       (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [D-1:0] rand_vec(input int sparse);
        logic [D-1:0] v;
        for (int w = 0; w < D / 32; w++) begin
            logic [31:0] word;
            word = $urandom;
            if (sparse != 0) word = word & $urandom & $urandom;
            v[w*32 +: 32] = word;
        end
        return v;
    endfunction

    function automatic logic [D-1:0] vec_ones(input int k);
        logic [D-1:0] v;
        int r;
        v = '0;
        for (int i = 0; i < k; i++) v[i] = 1'b1;
        r = $urandom_range(D - 1, 1);
        return (v << r) | (v >> (D - r));
    endfunction

    task automatic fill_random(input int sparse);
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < NC; c++)
                seg_data[s][c] = rand_vec(sparse);
    endtask

    task automatic fill_zero();
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < NC; c++)
                seg_data[s][c] = '0;
    endtask

    // Reference: total matching bits per class over slots 0..3, first maximum wins.
    task automatic model(output logic [CW-1:0] cls, output logic [SW-1:0] score);
        int sums [NC];
        int best;
        int bi;
        for (int c = 0; c < NC; c++) begin
            sums[c] = 0;
            for (int s = 0; s < S; s++) sums[c] += $countones(seg_data[s][c]);
        end
        best = 0;
        bi   = 0;
        for (int c = 0; c < NC; c++) begin
            if (sums[c] > best) begin
                best = sums[c];
                bi   = c;
            end
        end
        cls   = CW'(bi);
        score = SW'(best);
    endtask

    task automatic send_seg(input int q, input int slot);
        @(negedge clk);
        seg_valid = 1'b1;
        query_ctr = 2'(q);
        for (int c = 0; c < NC; c++) and_array_out[c] = seg_data[slot][c];
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    task automatic send_query();
        for (int s = 0; s < S; s++) send_seg(s, s);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!result_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (seg_ready !== 1'b1 || result_valid !== 1'b0 || pred_class !== '0 ||
            pred_score !== '0 || seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b rv=%b cls=%0d sc=%0d err=%b expected 1 0 0 0 0",
                     seg_ready, result_valid, pred_class, pred_score, seq_err);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_single_query();
        logic [CW-1:0] ec;
        logic [SW-1:0] es;
        int lat;
        fill_zero();
        for (int s = 0; s < S; s++) seg_data[s][7] = '1;
        model(ec, es);
        send_query();
        n_vec++;
        if (seg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready_in_scan: got %b expected 0", seg_ready);
        end
        wait_result(lat);
        n_vec++;
        if (lat != 26) begin
            n_err++;
            $display("FAIL single_latency: got %0d edges expected 26", lat);
        end
        n_vec++;
        if (pred_class !== ec || pred_score !== es || pred_score !== 13'd4096) begin
            n_err++;
            $display("FAIL single_result: got class %0d score %0d expected %0d %0d",
                     pred_class, pred_score, ec, es);
        end
        take_result();
        n_vec++;
        if (seg_ready !== 1'b1 || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: rdy=%b rv=%b expected 1 0", seg_ready, result_valid);
        end
    endtask

    task automatic test_tie();
        logic [CW-1:0] ec;
        logic [SW-1:0] es;
        int lat;
        for (int s = 0; s < S; s++) begin
            for (int c = 0; c < NC; c++) seg_data[s][c] = vec_ones((c * 13 + s * 5) % 120);
            seg_data[s][3]  = vec_ones(125);
            seg_data[s][12] = vec_ones(125);
        end
        model(ec, es);
        send_query();
        wait_result(lat);
        n_vec++;
        if (lat != 26 || pred_class !== ec || pred_score !== es ||
            pred_class !== 5'd3 || pred_score !== 13'd500) begin
            n_err++;
            $display("FAIL tie: got class %0d score %0d lat %0d expected %0d %0d lat 26",
                     pred_class, pred_score, lat, ec, es);
        end
        take_result();
    endtask

    task automatic test_back_pressure();
        logic [CW-1:0] ec;
        logic [SW-1:0] es;
        int lat;
        fill_random(1);
        model(ec, es);
        send_query();
        wait_result(lat);
        n_vec++;
        if (pred_class !== ec || pred_score !== es) begin
            n_err++;
            $display("FAIL bp_result: got class %0d score %0d expected %0d %0d",
                     pred_class, pred_score, ec, es);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seg_valid = 1'b1;
            query_ctr = 2'd0;
            n_vec++;
            if (pred_class !== ec || pred_score !== es || seg_ready !== 1'b0 || result_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: class %0d score %0d rdy %b rv %b expected %0d %0d 0 1",
                         i, pred_class, pred_score, seg_ready, result_valid, ec, es);
            end
        end
        seg_valid = 1'b0;
        take_result();
        n_vec++;
        if (seg_ready !== 1'b1 || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: rdy=%b rv=%b expected 1 0", seg_ready, result_valid);
        end
        fill_random(0);
        model(ec, es);
        send_query();
        wait_result(lat);
        n_vec++;
        if (lat != 26 || pred_class !== ec || pred_score !== es) begin
            n_err++;
            $display("FAIL bp_second_query: got class %0d score %0d lat %0d expected %0d %0d lat 26",
                     pred_class, pred_score, lat, ec, es);
        end
        take_result();
    endtask

    task automatic test_out_of_order();
        logic [CW-1:0] ec;
        logic [SW-1:0] es;
        int lat;
        fill_random(1);
        for (int c = 0; c < NC; c++) seg_data[4][c] = '1;
        seg_data[4][19] = '1;
        model(ec, es);
        send_seg(0, 0);
        send_seg(2, 4);
        n_vec++;
        if (seq_err !== 1'b1 || seg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ooo_flag: seq_err=%b rdy=%b expected 1 1", seq_err, seg_ready);
        end
        send_seg(1, 1);
        send_seg(2, 2);
        send_seg(3, 3);
        wait_result(lat);
        n_vec++;
        if (lat != 26 || pred_class !== ec || pred_score !== es || seq_err !== 1'b1) begin
            n_err++;
            $display("FAIL ooo_result: got class %0d score %0d lat %0d err %b expected %0d %0d lat 26 err 1",
                     pred_class, pred_score, lat, seq_err, ec, es);
        end
        take_result();
    endtask

    task automatic test_reset_midscan();
        logic [CW-1:0] ec;
        logic [SW-1:0] es;
        int lat;
        fill_random(0);
        send_query();
        repeat (10) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        n_vec++;
        if (result_valid !== 1'b0 || seg_ready !== 1'b1 || seq_err !== 1'b0 ||
            pred_class !== '0 || pred_score !== '0) begin
            n_err++;
            $display("FAIL midscan_reset: rv=%b rdy=%b err=%b cls=%0d sc=%0d expected 0 1 0 0 0",
                     result_valid, seg_ready, seq_err, pred_class, pred_score);
        end
        @(negedge clk);
        nrst = 1'b1;
        fill_random(1);
        model(ec, es);
        send_query();
        wait_result(lat);
        n_vec++;
        if (lat != 26 || pred_class !== ec || pred_score !== es || seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL midscan_requery: got class %0d score %0d lat %0d err %b expected %0d %0d lat 26 err 0",
                     pred_class, pred_score, lat, seq_err, ec, es);
        end
        take_result();
    endtask

    task automatic test_all_zero();
        int lat;
        fill_zero();
        send_query();
        wait_result(lat);
        n_vec++;
        if (lat != 26 || pred_class !== '0 || pred_score !== '0) begin
            n_err++;
            $display("FAIL all_zero: got class %0d score %0d lat %0d expected 0 0 lat 26",
                     pred_class, pred_score, lat);
        end
        take_result();
    endtask

    task automatic test_random_queries();
        logic [CW-1:0] ec;
        logic [SW-1:0] es;
        int lat;
        for (int n = 0; n < 6; n++) begin
            fill_random(n % 2);
            if (n >= 2) begin
                for (int s = 0; s < S; s++)
                    seg_data[s][$urandom_range(NC - 1, 0)] = rand_vec(0) | rand_vec(0);
            end
            model(ec, es);
            send_query();
            wait_result(lat);
            n_vec++;
            if (lat != 26 || pred_class !== ec || pred_score !== es) begin
                n_err++;
                $display("FAIL random_query %0d: got class %0d score %0d lat %0d expected %0d %0d lat 26",
                         n, pred_class, pred_score, lat, ec, es);
            end
            take_result();
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        nrst         = 1'b0;
        seg_valid    = 1'b0;
        result_ready = 1'b0;
        query_ctr    = 2'd0;
        for (int c = 0; c < NC; c++) and_array_out[c] = '0;

        test_reset();
        test_single_query();
        test_tie();
        test_back_pressure();
        test_out_of_order();
        test_reset_midscan();
        test_all_zero();
        test_random_queries();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/am_similarity_argmax.md
# am_similarity_argmax

Consumer stage of the associative-memory (AM) search. It accepts the per-class AND-array outputs for the `SEQ_CYCLE_COUNT` query segments. For each class it popcounts and accumulates the matching-bit score across segments. It then scans the 26 class scores sequentially and returns the best-matching class through a valid/ready result port. It sits between the AM AND array and the classifier output logic.

## Interface

**Parameters**
- `DIMS_PER_CC`, default 1024: bits per query segment.
- `SEQ_CYCLE_COUNT`, default 4: segments per query.
- `NUM_CLASSES`, default 26: class hypervectors.
- `SCORE_W`, default 13: `$clog2(DIMS_PER_CC*SEQ_CYCLE_COUNT+1)`.
- `CLASS_W`, default 5: `$clog2(NUM_CLASSES)`.

**Ports**
- `clk` in 1: the single clock; all state updates on its rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `seg_valid` in 1: segment data is present.
- `seg_ready` out 1: the block can accept a segment.
- `query_ctr` in 2: index of the presented segment, 0..3.
- `and_array_out` in `[DIMS_PER_CC-1:0]` × `[0:NUM_CLASSES-1]`: per-class AND of the class HV segment and the query segment.
- `result_valid` out 1: prediction is available.
- `result_ready` in 1: downstream accepts the prediction.
- `pred_class` out `CLASS_W`: index of the winning class.
- `pred_score` out `SCORE_W`: score of the winning class.
- `seq_err` out 1: sticky flag for an out-of-order segment.

## Operation

**States**
- `ACCUM`: reset state.
- `ARGMAX`
- `DONE`

**ACCUM**
- `seg_ready`=1.
- Accept fires when `seg_valid && seg_ready`.
- On accept with `query_ctr == exp_ctr`:
  - `acc[i] += popcount(and_array_out[i])` for all i.
  - `exp_ctr++`.
- On accept with `query_ctr != exp_ctr`:
  - segment is discarded.
  - `seq_err` is set and stays set until reset.
  - `exp_ctr` and accumulators are unchanged.
- An accepted in-order segment with `exp_ctr == SEQ_CYCLE_COUNT-1` moves the block to `ARGMAX`:
  - `exp_ctr` wraps to 0.
  - scan index `idx` is cleared.
  - `best_score`=0 and `best_class`=0.

**ARGMAX**
- `seg_ready`=0.
- Each cycle compares `acc[idx]`:
  - if `acc[idx] > best_score` (strictly greater), it loads `best_score`/`best_class`.
  - `idx++`.
- Ties resolve to the lowest class index.
- After `idx == NUM_CLASSES-1` is compared, the block moves to `DONE`.

**DONE**
- `result_valid`=1.
- `pred_class`/`pred_score` are held stable until `result_ready`.
- On `result_valid && result_ready`:
  - all `acc` are cleared to 0.
  - the block returns to `ACCUM`.

**Arithmetic**
- Popcount is `SCORE_W` wide and unsigned.
- Maximum `acc` is 4096; it cannot overflow `SCORE_W`=13.

**Reset**
- Asynchronous, any state, including mid-accumulation and mid-scan.
- Clears all `acc`, `exp_ctr`, `idx`, `best_*` and `seq_err`.
- State returns to `ACCUM`.
- Output values:
  - `seg_ready`=1 (state `ACCUM`).
  - `result_valid`=0.
  - `pred_class`=0.
  - `pred_score`=0.
  - `seq_err`=0.

## Timing
- The accumulate happens on the accept edge; there is no popcount pipeline stage.
- `seg_ready` is a pure function of the state.
- Latency:
  - the last-segment accept at edge E0 puts the block in `ARGMAX`.
  - indices 0..25 are compared at edges E1..E26.
  - `result_valid` rises after E26, i.e. 26 edges after the last accept.
- `result_ready` held high: `DONE` lasts one cycle and `seg_ready` returns the following cycle.
- Outputs do not change while `result_valid`=1 and `result_ready`=0.
- Minimum query period is `SEQ_CYCLE_COUNT` + `NUM_CLASSES` + 1 = 31 cycles.
- `seg_valid` during `ARGMAX`/`DONE` is ignored (not accepted).

## Structure
- A shared package `am_pkg` holds:
  - `DIMS_PER_CC`, `SEQ_CYCLE_COUNT`, `NUM_CLASSES`, `SCORE_W`, `CLASS_W`.
  - the `am_state_t` enum (`ACCUM`, `ARGMAX`, `DONE`).
  - `score_t` (`logic [SCORE_W-1:0]`).
- One sub-module, `am_popcount`: a parameterised `DIMS_PER_CC`-bit adder-tree popcount with `SCORE_W` output.
  - Instantiated `NUM_CLASSES` times in a generate loop.

## Test plan
- **Single query:** segments 0..3 where class 7 has all 1024 bits set in every segment and every other class has 0 → `result_valid` 26 edges after the 4th accept, `pred_class`=7, `pred_score`=4096.
- **Tie:** classes 3 and 12 each total 500 and all others are lower → `pred_class`=3, `pred_score`=500.
- **Back-pressure:** hold `result_ready`=0 for 10 cycles → `pred_*` stable and `seg_ready`=0 throughout; `result_ready`=1 → `ACCUM` next cycle with all `acc`=0. A second query then gives an independent result.
- **Out-of-order:** present `query_ctr`=0, then 2 → `seq_err`=1 and the segment is dropped. Then present 1, 2, 3 → the result is computed from segments 0..3 only.
- **Reset mid-scan:** assert `nrst`=0 at `idx`=10 → immediately `result_valid`=0 and `seg_ready`=1. A following full query gives the correct result with `seq_err`=0.
- **All-zero input:** every `and_array_out` is 0 → `pred_class`=0, `pred_score`=0.
